// File: rtl/barrel_pkg.sv
// Shared defaults and mode encodings for the pipelined left barrel shifter.
package barrel_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int SHW_DEF   = 4;

  typedef enum logic {
    MODE_SHL = 1'b0,
    MODE_ROL = 1'b1
  } mode_e;
endpackage

// File: rtl/bs_left_stage.sv
// One pipeline stage: conditional shift/rotate left by 2^K plus its stage register.
import barrel_pkg::*;

module bs_left_stage #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic [SHW-1:0]   up_mag,
  input  mode_e            up_rot,
  input  logic             dn_load,
  output logic             load,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [SHW-1:0]   mag,
  output mode_e            rot
);
  localparam int           S     = 1 << K;
  localparam logic [SHW-1:0] KMASK = ~(SHW'(1) << K);

  logic [WIDTH-1:0] nxt;

  always_comb begin
    nxt = up_data;
    if (up_mag[K]) begin
      if (up_rot == MODE_ROL) nxt = {up_data[WIDTH-S-1:0], up_data[WIDTH-1:WIDTH-S]};
      else                    nxt = {up_data[WIDTH-S-1:0], {S{1'b0}}};
    end
  end

  // A stage may refill when empty or when its contents move on this cycle.
  assign load = !valid || dn_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      mag   <= '0;
      rot   <= MODE_SHL;
    end else if (load) begin
      valid <= up_valid;
      data  <= nxt;
      mag   <= up_mag & KMASK;
      rot   <= up_rot;
    end
  end
endmodule

// File: rtl/barrel_shifter_left_pipe.sv
// Pipelined left shifter/rotator: SHW elastic stages, one bit of Shift_Mag per stage.
import barrel_pkg::*;

module barrel_shifter_left_pipe #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] Inp,
  input  logic [SHW-1:0]   Shift_Mag,
  input  logic             Rotate,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Outp
);
  logic [SHW:0]            vld;
  logic [SHW:0]            ld;
  logic [SHW:0][WIDTH-1:0] dat;
  logic [SHW:0][SHW-1:0]   mag;
  mode_e                   rot [SHW:0];

  assign vld[0]  = In_Valid;
  assign dat[0]  = Inp;
  assign mag[0]  = Shift_Mag;
  assign rot[0]  = mode_e'(Rotate);
  assign ld[SHW] = Out_Ready;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    bs_left_stage #(.WIDTH(WIDTH), .SHW(SHW), .K(k)) u_stage (
      .clk      (Clk),
      .rst      (Rst),
      .up_valid (vld[k]),
      .up_data  (dat[k]),
      .up_mag   (mag[k]),
      .up_rot   (rot[k]),
      .dn_load  (ld[k+1]),
      .load     (ld[k]),
      .valid    (vld[k+1]),
      .data     (dat[k+1]),
      .mag      (mag[k+1]),
      .rot      (rot[k+1])
    );
  end

  assign In_Ready  = ld[0];
  assign Out_Valid = vld[SHW];
  assign Outp      = dat[SHW];

  // Fully consumed shift bits and mode of the last stage have no consumer.
  logic unused_tail;
  assign unused_tail = ^{mag[SHW], rot[SHW]};
endmodule

// File: tb/tb_barrel_shifter_left_pipe.sv
// Randomized and directed checks of barrel_shifter_left_pipe against a queue-based reference.
module tb_barrel_shifter_left_pipe;
  localparam int W  = 16;
  localparam int SW = 4;

  logic          Clk = 0, Rst = 1;
  logic          In_Valid = 0, In_Ready, Rotate = 0, Out_Valid, Out_Ready = 0;
  logic [W-1:0]  Inp = '0, Outp;
  logic [SW-1:0] Shift_Mag = '0;

  barrel_shifter_left_pipe #(.WIDTH(W), .SHW(SW)) dut (
    .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .In_Ready(In_Ready), .Inp(Inp),
    .Shift_Mag(Shift_Mag), .Rotate(Rotate), .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready), .Outp(Outp)
  );

  always #5 Clk = ~Clk;

  int nchk = 0, nfail = 0, cyc = 0;
  int unsigned exp_q[$];
  int acc_q[$];
  bit lat_on = 0, rnd_rdy = 0, hold_v = 0;
  logic [W-1:0] hold_d;

  task automatic chk(string tag, longint got, longint exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int unsigned ref_fn(int unsigned a, int unsigned s, bit rol);
    int unsigned r;
    r = (a << s) & 32'hFFFF;
    if (rol) r = r | ((a >> (W - s)) & 32'hFFFF);
    return r;
  endfunction

  always @(posedge Clk) cyc++;

  always @(posedge Clk) if (rnd_rdy) begin
    #1 Out_Ready = ($urandom_range(0, 2) != 0);
  end

  // Scoreboard: capture accepted operands, check delivered results and hold stability.
  always @(negedge Clk) begin
    if (Rst) hold_v = 0;
    else begin
      if (hold_v) begin
        chk("hold_valid", Out_Valid, 1);
        chk("hold_data", Outp, hold_d);
      end
      hold_v = Out_Valid && !Out_Ready;
      hold_d = Outp;
      if (In_Valid && In_Ready) begin
        exp_q.push_back(ref_fn(Inp, Shift_Mag, Rotate));
        acc_q.push_back(cyc);
      end
      if (Out_Valid && Out_Ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          int a;
          chk("result", Outp, exp_q.pop_front());
          a = acc_q.pop_front();
          if (lat_on) chk("latency", cyc - a, SW);
        end
      end
    end
  end

  task automatic send(int unsigned a, int unsigned s, bit r);
    bit acc;
    In_Valid = 1; Inp = W'(a); Shift_Mag = SW'(s); Rotate = r;
    for (int n = 0; n < 500; n++) begin
      @(negedge Clk); acc = In_Ready;
      @(posedge Clk); #1;
      if (acc) begin In_Valid = 0; return; end
    end
    In_Valid = 0;
    chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int n = 0; n < 2000; n++) begin
      if (exp_q.size() == 0) return;
      @(posedge Clk); #1;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int acc_cnt, ov_cnt;
    bit pat [4] = '{1, 0, 1, 0};
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_out_valid", Out_Valid, 0);
    chk("rst_outp", Outp, 0);
    Rst = 0;
    @(negedge Clk);
    chk("rst_in_ready", In_Ready, 1);
    @(posedge Clk); #1;

    // Directed shifts with latency checking.
    Out_Ready = 1; lat_on = 1;
    send(16'h0001, 15, 0); drain();
    send(16'h8001, 1, 1);  drain();
    send(16'h8001, 1, 0);  drain();
    send(16'hA5A5, 0, 0);  drain();
    send(16'hA5A5, 0, 1);  drain();
    send(16'hF00F, 4, 1);  send(16'hF00F, 8, 0); drain();

    // Bubbles: Out_Valid must echo the input pattern four cycles later.
    for (int i = 0; i < 10; i++) begin
      In_Valid = (i < 4) ? pat[i] : 1'b0;
      Inp = W'($urandom); Shift_Mag = SW'($urandom); Rotate = $urandom_range(0, 1);
      @(negedge Clk);
      chk("bubble_ov", Out_Valid, (i >= SW && i < SW + 4) ? pat[i-SW] : 1'b0);
      @(posedge Clk); #1;
    end
    In_Valid = 0; drain();

    // Backpressure: four accepted into a stalled pipe, then drain with no gaps.
    lat_on = 0; Out_Ready = 0; acc_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      In_Valid = 1; Inp = W'(16'h1111 * (acc_cnt + 1)); Shift_Mag = SW'(acc_cnt); Rotate = acc_cnt[0];
      @(negedge Clk); if (In_Ready) acc_cnt++;
      @(posedge Clk); #1;
    end
    chk("bp_accepted", acc_cnt, SW);
    chk("bp_in_ready", In_Ready, 0);
    Out_Ready = 1; ov_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      In_Valid = (acc_cnt < 6);
      Inp = W'(16'h1111 * (acc_cnt + 1)); Shift_Mag = SW'(acc_cnt); Rotate = acc_cnt[0];
      @(negedge Clk); if (In_Valid && In_Ready) acc_cnt++;
      if (Out_Valid) ov_cnt++;
      @(posedge Clk); #1;
    end
    In_Valid = 0;
    chk("bp_no_gaps", ov_cnt, 6);
    chk("bp_total", acc_cnt, 6);
    drain();

    // Reset with three results in flight.
    send(16'h1234, 3, 0); send(16'h5678, 5, 1); send(16'h9ABC, 7, 0);
    Rst = 1; #1;
    chk("midrst_out_valid", Out_Valid, 0);
    chk("midrst_outp", Outp, 0);
    exp_q.delete(); acc_q.delete();
    @(posedge Clk); #1; Rst = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk); chk("post_rst_idle", Out_Valid, 0);
    end
    @(posedge Clk); #1;
    lat_on = 1;
    send(16'h00FF, 8, 1); drain();

    // Random traffic with random consumer stalls.
    lat_on = 0; rnd_rdy = 1;
    for (int i = 0; i < 10000; i++) begin
      int unsigned s;
      s = (i % 37 == 0) ? 0 : (i % 37 == 1) ? 15 : $urandom_range(0, W - 1);
      send($urandom & 32'hFFFF, s, $urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin @(posedge Clk); #1; end
    end
    drain();
    rnd_rdy = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
